// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data-memory request/acknowledge bus between the MEM stage and memory
interface mem_stage_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM pipeline stage: branch resolve, multi-cycle memory access, MEM/WB register
module mem_stage_ctrl #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_reg_in,
  input  logic                     mem_to_reg_in,
  input  logic                     write_mem_in,
  input  logic                     branch_in,
  input  logic [31:0]              next_address_in,
  input  logic                     zero_in,
  input  logic [31:0]              alu_result_in,
  input  logic [31:0]              r2_output_in,
  input  logic [4:0]               register_in,
  mem_stage_ctrl_if.master         mem,
  output logic                     stall,
  output logic                     pc_src,
  output logic [31:0]              branch_target,
  output logic                     wb_write_reg,
  output logic                     wb_mem_to_reg,
  output logic [31:0]              wb_read_data,
  output logic [31:0]              wb_alu_result,
  output logic [4:0]               wb_register,
  output logic                     bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last counter value before giving up on the memory; counter is 16 bits wide
  // to cover the full TIMEOUT range.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic        wb_write_reg_q, wb_write_reg_d;
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [31:0] wb_read_data_q, wb_read_data_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [4:0]  wb_register_q, wb_register_d;

  logic        access;
  logic        stall_c;

  // Next-state, memory-bus and MEM/WB update logic; everything defaults to hold.
  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    cnt_d           = cnt_q;
    bus_err_d       = bus_err_q;
    wb_write_reg_d  = wb_write_reg_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_read_data_d  = wb_read_data_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_register_d   = wb_register_q;

    access  = mem_to_reg_in | write_mem_in;
    stall_c = ((state_q == S_IDLE) && access) || (state_q == S_BUSY);

    case (state_q)
      S_IDLE: begin
        if (access) begin
          state_d = S_BUSY;
          req_d   = 1'b1;
          // A store wins when both load and store flags are set.
          we_d    = write_mem_in;
          addr_d  = alu_result_in;
          wdata_d = r2_output_in;
          cnt_d   = 16'd0;
        end
      end
      S_BUSY: begin
        // An ack in the final counted cycle still wins over the timeout.
        if (mem.mem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          rdata_d = mem.mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          rdata_d   = ERR_DATA;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // MEM/WB advances whenever the stage is not stalled; otherwise a bubble.
    if (!stall_c) begin
      wb_write_reg_d  = write_reg_in;
      wb_mem_to_reg_d = mem_to_reg_in;
      wb_alu_result_d = alu_result_in;
      wb_register_d   = register_in;
      wb_read_data_d  = rdata_q;
    end else begin
      wb_write_reg_d  = 1'b0;
      wb_mem_to_reg_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-bus, timeout and MEM/WB registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      rdata_q         <= 32'd0;
      cnt_q           <= 16'd0;
      bus_err_q       <= 1'b0;
      wb_write_reg_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_read_data_q  <= 32'd0;
      wb_alu_result_q <= 32'd0;
      wb_register_q   <= 5'd0;
    end else begin
      req_q           <= req_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      cnt_q           <= cnt_d;
      bus_err_q       <= bus_err_d;
      wb_write_reg_q  <= wb_write_reg_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_register_q   <= wb_register_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign stall         = stall_c;
  assign pc_src        = branch_in & zero_in & ~stall_c;
  assign branch_target = next_address_in;

  assign wb_write_reg  = wb_write_reg_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_register   = wb_register_q;
  assign bus_err       = bus_err_q;

endmodule
